// File: rtl/fpu_8_pkg.sv
// Shared types and constants for the 8-bit FPU issue sequencer.
package fpu_8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fsm_state_t;

    localparam int REQ_W = 19;

    // Field order matches the packing used at the FIFO write port.
    typedef struct packed {
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [1:0] operation;
        logic       round_mode;
    } req_t;

endpackage

// File: rtl/fpu_8_req_fifo.sv
// Parameterised synchronous request FIFO with full/empty/count status.
module fpu_8_req_fifo
    import fpu_8_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_DEPTH);
    assign empty    = (count == '0);

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_8_issue.sv
// Request-buffering issue sequencer in front of the 8-bit FPU.
// Optional feature macro: FPU8_STICKY_EXC_EN adds STICKY_EXC and EXC_COUNT.
module fpu_8_issue
    import fpu_8_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FPU_LATENCY = 1
) (
    input  logic        FP_CLK,
    input  logic        FP_RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [7:0]  REQ_OP_A,
    input  logic [7:0]  REQ_OP_B,
    input  logic [1:0]  REQ_OPERATION,
    input  logic        REQ_ROUND_MODE,
    output logic        FPU_START,
    output logic [7:0]  FPU_OP_A,
    output logic [7:0]  FPU_OP_B,
    output logic [1:0]  FPU_OPERATION,
    output logic        FPU_ROUND_MODE,
    input  logic [7:0]  FPU_RESULT,
    input  logic        FPU_IS_EXCEPTION,
    input  logic [2:0]  FPU_EXCEPTION,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [7:0]  RSP_RESULT,
    output logic        RSP_IS_EXCEPTION,
    output logic [2:0]  RSP_EXCEPTION,
`ifdef FPU8_STICKY_EXC_EN
    output logic [2:0]  STICKY_EXC,
    output logic [7:0]  EXC_COUNT,
`endif
    output logic        BUSY
);

    localparam logic [2:0] LAT_INIT = 3'(FPU_LATENCY - 1);

    fsm_state_t             state;
    fsm_state_t             state_next;
    logic [2:0]             lat_cnt;
    logic [2:0]             lat_cnt_next;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [REQ_W-1:0]       fifo_rd_data;
    req_t                   head;
    logic                   capture;

    assign fifo_push = REQ_VALID && !fifo_full;
    assign REQ_READY = !fifo_full;
    assign BUSY      = (fifo_count != '0) || (state != IDLE);
    assign head      = fifo_rd_data;

    fpu_8_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clock     (FP_CLK),
        .reset     (FP_RST),
        .push      (fifo_push),
        .push_data ({REQ_OP_A, REQ_OP_B, REQ_OPERATION, REQ_ROUND_MODE}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        fifo_pop     = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_next = LAT_INIT;
                state_next   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt - 3'd1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // START and VALID are registered from the next state so they line up
    // exactly with the ISSUE and RESP states.
    always_ff @(posedge FP_CLK) begin
        if (FP_RST) begin
            state            <= IDLE;
            lat_cnt          <= '0;
            FPU_START        <= 1'b0;
            FPU_OP_A         <= '0;
            FPU_OP_B         <= '0;
            FPU_OPERATION    <= '0;
            FPU_ROUND_MODE   <= 1'b0;
            RSP_VALID        <= 1'b0;
            RSP_RESULT       <= '0;
            RSP_IS_EXCEPTION <= 1'b0;
            RSP_EXCEPTION    <= '0;
        end else begin
            state     <= state_next;
            lat_cnt   <= lat_cnt_next;
            FPU_START <= (state_next == ISSUE);
            RSP_VALID <= (state_next == RESP);
            if (fifo_pop) begin
                FPU_OP_A       <= head.op_a;
                FPU_OP_B       <= head.op_b;
                FPU_OPERATION  <= head.operation;
                FPU_ROUND_MODE <= head.round_mode;
            end
            if (capture) begin
                RSP_RESULT       <= FPU_RESULT;
                RSP_IS_EXCEPTION <= FPU_IS_EXCEPTION;
                RSP_EXCEPTION    <= FPU_EXCEPTION;
            end
        end
    end

`ifdef FPU8_STICKY_EXC_EN
    always_ff @(posedge FP_CLK) begin
        if (FP_RST) begin
            STICKY_EXC <= '0;
            EXC_COUNT  <= '0;
        end else if (capture && FPU_IS_EXCEPTION) begin
            STICKY_EXC <= STICKY_EXC | FPU_EXCEPTION;
            if (EXC_COUNT != 8'hFF) begin
                EXC_COUNT <= EXC_COUNT + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_8_issue.sv
// Directed self-checking bench for fpu_8_issue (latency 1 and latency 3 instances).
module tb_fpu_8_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready;
    logic [7:0] req_op_a, req_op_b;
    logic [1:0] req_operation;
    logic       req_round_mode;
    logic       fpu_start;
    logic [7:0] fpu_op_a, fpu_op_b;
    logic [1:0] fpu_operation;
    logic       fpu_round_mode;
    logic [7:0] fpu_result;
    logic       fpu_is_exception;
    logic [2:0] fpu_exception;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_is_exception;
    logic [2:0] rsp_exception;
    logic       busy;
    logic       exc_force;

    logic       req_valid3, req_ready3, fpu_start3, fpu_round_mode3;
    logic [7:0] fpu_op_a3, fpu_op_b3, fpu3_result, rsp_result3;
    logic [1:0] fpu_operation3;
    logic       rsp_valid3, rsp_ready3, rsp_is_exception3, busy3;
    logic [2:0] rsp_exception3;

`ifdef FPU8_STICKY_EXC_EN
    logic [2:0] sticky_exc, sticky_exc3;
    logic [7:0] exc_count, exc_count3;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int start_count = 0;
    logic [7:0] rsp_log [$];

    fpu_8_issue #(.DEPTH(4), .FPU_LATENCY(1)) dut (
        .FP_CLK(clk), .FP_RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_OP_A(req_op_a), .REQ_OP_B(req_op_b),
        .REQ_OPERATION(req_operation), .REQ_ROUND_MODE(req_round_mode),
        .FPU_START(fpu_start), .FPU_OP_A(fpu_op_a), .FPU_OP_B(fpu_op_b),
        .FPU_OPERATION(fpu_operation), .FPU_ROUND_MODE(fpu_round_mode),
        .FPU_RESULT(fpu_result), .FPU_IS_EXCEPTION(fpu_is_exception),
        .FPU_EXCEPTION(fpu_exception),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RESULT(rsp_result),
        .RSP_IS_EXCEPTION(rsp_is_exception), .RSP_EXCEPTION(rsp_exception),
`ifdef FPU8_STICKY_EXC_EN
        .STICKY_EXC(sticky_exc), .EXC_COUNT(exc_count),
`endif
        .BUSY(busy)
    );

    fpu_8_issue #(.DEPTH(4), .FPU_LATENCY(3)) dut3 (
        .FP_CLK(clk), .FP_RST(rst),
        .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
        .REQ_OP_A(8'h21), .REQ_OP_B(8'h43),
        .REQ_OPERATION(2'b01), .REQ_ROUND_MODE(1'b1),
        .FPU_START(fpu_start3), .FPU_OP_A(fpu_op_a3), .FPU_OP_B(fpu_op_b3),
        .FPU_OPERATION(fpu_operation3), .FPU_ROUND_MODE(fpu_round_mode3),
        .FPU_RESULT(fpu3_result), .FPU_IS_EXCEPTION(1'b0),
        .FPU_EXCEPTION(3'b000),
        .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3), .RSP_RESULT(rsp_result3),
        .RSP_IS_EXCEPTION(rsp_is_exception3), .RSP_EXCEPTION(rsp_exception3),
`ifdef FPU8_STICKY_EXC_EN
        .STICKY_EXC(sticky_exc3), .EXC_COUNT(exc_count3),
`endif
        .BUSY(busy3)
    );

    // Toy FPU: a simple integer op per opcode, exception forced by the bench.
    always_comb begin
        fpu_result = 8'h00;
        case (fpu_operation)
            2'b00: fpu_result = fpu_op_a + fpu_op_b;
            2'b01: fpu_result = fpu_op_a - fpu_op_b;
            2'b10: fpu_result = fpu_op_a ^ fpu_op_b;
            2'b11: fpu_result = fpu_op_a & fpu_op_b;
            default: fpu_result = 8'h00;
        endcase
        fpu_is_exception = exc_force;
        fpu_exception    = exc_force ? 3'b101 : 3'b000;
    end

    always @(posedge clk) begin
        if (fpu_start) start_count <= start_count + 1;
        if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_result);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] op, input logic rnd);
        int waited = 0;
        req_valid      = 1'b1;
        req_op_a       = a;
        req_op_b       = b;
        req_operation  = op;
        req_round_mode = rnd;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("push_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitRsp();
        int waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("rsp_arrives", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int s0;
        int waited;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; exc_force = 1'b0;
        req_op_a = '0; req_op_b = '0; req_operation = '0; req_round_mode = 1'b0;
        req_valid3 = 1'b0; rsp_ready3 = 1'b0; fpu3_result = 8'h11;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_fpu_start", 32'(fpu_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fpu_op_a", 32'(fpu_op_a), 32'd0);
        checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("rst_req_ready3", 32'(req_ready3), 32'd1);
`ifdef FPU8_STICKY_EXC_EN
        checkOutput("rst_sticky", 32'(sticky_exc), 32'd0);
        checkOutput("rst_exc_count", 32'(exc_count), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single op");
        rsp_ready = 1'b1;
        s0 = start_count;
        applyStimulus(8'h3C, 8'h40, 2'b00, 1'b0);
        @(posedge clk); #1;
        checkOutput("single_start", 32'(fpu_start), 32'd1);
        checkOutput("single_op_a", 32'(fpu_op_a), 32'h3C);
        checkOutput("single_op_b", 32'(fpu_op_b), 32'h40);
        @(posedge clk); #1;
        checkOutput("single_start_off", 32'(fpu_start), 32'd0);
        checkOutput("single_not_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single_result", 32'(rsp_result), 32'h7C);
        checkOutput("single_is_exc", 32'(rsp_is_exception), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_accepted", 32'(rsp_valid), 32'd0);
        checkOutput("single_one_start", 32'(start_count - s0), 32'd1);
        checkOutput("single_idle", 32'(busy), 32'd0);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(8'h55, 8'h0F, 2'b10, 1'b1);
        waitRsp();
        s0 = start_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_result", 32'(rsp_result), 32'h5A);
            checkOutput("bp_no_start", 32'(start_count - s0), 32'd0);
        end
        checkOutput("bp_op_held", 32'(fpu_operation), 32'd2);
        checkOutput("bp_round_held", 32'(fpu_round_mode), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_accepted", 32'(rsp_valid), 32'd0);

        $display("[TB] exception");
        exc_force = 1'b1;
        applyStimulus(8'h81, 8'h7F, 2'b11, 1'b0);
        waitRsp();
        checkOutput("exc_result", 32'(rsp_result), 32'h01);
        checkOutput("exc_flag", 32'(rsp_is_exception), 32'd1);
        checkOutput("exc_code", 32'(rsp_exception), 32'h5);
`ifdef FPU8_STICKY_EXC_EN
        checkOutput("exc_sticky", 32'(sticky_exc), 32'h5);
        checkOutput("exc_count", 32'(exc_count), 32'd1);
`endif
        @(posedge clk); #1;
        exc_force = 1'b0;
        checkOutput("exc_accepted", 32'(rsp_valid), 32'd0);

        $display("[TB] fill");
        rsp_ready = 1'b0;
        rsp_log.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h10 + 8'(i), 8'h01, 2'b00, 1'b0);
        end
        checkOutput("fill_full", 32'(req_ready), 32'd0);
        checkOutput("fill_busy", 32'(busy), 32'd1);
        checkOutput("fill_first_rsp", 32'(rsp_result), 32'h11);
        rsp_ready = 1'b1;
        applyStimulus(8'h15, 8'h01, 2'b00, 1'b0);
        waited = 0;
        while (rsp_log.size() < 6 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("fill_rsp_count", 32'(rsp_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < rsp_log.size(); i++) begin
            checkOutput("fill_order", 32'(rsp_log[i]), 32'h11 + 32'(i));
        end

        $display("[TB] reset mid-wait");
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h20, 8'h01, 2'b00, 1'b0);
        applyStimulus(8'h21, 8'h01, 2'b00, 1'b0);
        applyStimulus(8'h22, 8'h01, 2'b00, 1'b0);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        s0 = start_count;
        @(posedge clk); #1;
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_busy_clr", 32'(busy), 32'd0);
        checkOutput("mid_req_ready", 32'(req_ready), 32'd1);
`ifdef FPU8_STICKY_EXC_EN
        checkOutput("mid_exc_count", 32'(exc_count), 32'd0);
`endif
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("mid_no_start", 32'(start_count - s0), 32'd0);
        checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);

        $display("[TB] latency 3");
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        waited = 0;
        while (!fpu_start3 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("lat3_start", 32'(fpu_start3), 32'd1);
        checkOutput("lat3_op_a", 32'(fpu_op_a3), 32'h21);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("lat3_not_early", 32'(rsp_valid3), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat3_still_wait", 32'(rsp_valid3), 32'd0);
        fpu3_result = 8'hA5;
        @(posedge clk); #1;
        checkOutput("lat3_valid", 32'(rsp_valid3), 32'd1);
        checkOutput("lat3_result", 32'(rsp_result3), 32'hA5);
        fpu3_result = 8'h5A;
        @(posedge clk); #1;
        checkOutput("lat3_result_held", 32'(rsp_result3), 32'hA5);
        checkOutput("lat3_valid_held", 32'(rsp_valid3), 32'd1);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        checkOutput("lat3_accepted", 32'(rsp_valid3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
